// File: rtl/riscv_pkg.sv
// Shared definitions for the CPU and its boot-time program loader.
package riscv_pkg;

    localparam int XLEN = 32;

    // Fetch starts here, so the loader places word 0 at this address.
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_HOLD,
        S_RUN,
        S_ERR
    } loader_state_t;

    // States in which the loader is willing to take program bytes.
    function automatic logic accepts_bytes(input loader_state_t s);
        return (s == S_IDLE) || (s == S_LOAD);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words. Presents the word
// being completed combinationally so the caller can register it on the
// same edge that accepts the final byte. Lanes above the current index
// are always zero, which gives zero padding for a short final word.
module byte_packer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [7:0]      data,
    input  logic            last,
    output logic [1:0]      idx,
    output logic [XLEN-1:0] word,
    output logic            word_done
);

    logic [XLEN-1:0] acc;

    // Current partial word with the incoming byte inserted at lane idx.
    assign word      = acc | (XLEN'(data) << {idx, 3'b000});
    // Word-complete / flush strobe: lane 3 filled or image ended.
    assign word_done = push && ((idx == 2'd3) || last);

    // Lane index and accumulator; cleared after each emitted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            idx <= 2'd0;
        end else if (push) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            if (word_done) begin
                acc <= '0;
                idx <= 2'd0;
            end else begin
                acc <= word;
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: streams bytes into instruction memory from
// RESET_PC upward, then releases the CPU via start after a fixed hold-off.
module prog_loader
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS  = 64,
    parameter int START_DELAY = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_valid,
    output logic            rx_ready,
    input  logic [7:0]      rx_byte,
    input  logic            rx_last,
    output logic            imem_we,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            start,
    output logic            load_done,
    output logic            err
);

    localparam int WCW = $clog2(IMEM_WORDS) + 1;

    loader_state_t   state, state_next;
    logic [WCW-1:0]  word_count;
    logic [7:0]      dcnt;

    logic            xfer;
    logic            overflow;
    logic            push;
    logic [1:0]      idx;
    logic [XLEN-1:0] word;
    logic            word_done;

    assign xfer     = rx_valid && rx_ready;
    // A byte that would open word IMEM_WORDS is refused; wins over rx_last.
    assign overflow = xfer && (word_count == WCW'(IMEM_WORDS)) && (idx == 2'd0);
    assign push     = xfer && !overflow;

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .data      (rx_byte),
        .last      (rx_last),
        .idx       (idx),
        .word      (word),
        .word_done (word_done)
    );

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        unique case (state)
            S_IDLE, S_LOAD: begin
                if (overflow)
                    state_next = S_ERR;
                else if (push && rx_last)
                    state_next = S_FLUSH;
                else if (push)
                    state_next = S_LOAD;
            end
            S_FLUSH: state_next = S_HOLD;
            S_HOLD: begin
                if (dcnt == 8'(START_DELAY - 1))
                    state_next = S_RUN;
            end
            S_RUN:   state_next = S_RUN;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Memory write port, word counter, hold-off counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            dcnt       <= 8'd0;
            start      <= 1'b0;
            load_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            rx_ready <= accepts_bytes(state_next);
            imem_we  <= push && word_done;
            if (push && word_done) begin
                imem_addr  <= RESET_PC + XLEN'({word_count, 2'b00});
                imem_wdata <= word;
                word_count <= word_count + 1'b1;
            end
            if (state == S_FLUSH) begin
                load_done <= 1'b1;
                dcnt      <= 8'd0;
            end else if (state == S_HOLD && state_next == S_HOLD) begin
                dcnt <= dcnt + 8'd1;
            end
            if (state_next == S_RUN)
                start <= 1'b1;
            if (state_next == S_ERR)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table-driven byte streams plus hand-written
// sequences for hold-off, back-pressure, overflow, reset and post-start.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_last = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        start;
    logic        load_done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  b;
        logic        last;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [13];

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    prog_loader #(
        .IMEM_WORDS  (4),
        .START_DELAY (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_byte    (rx_byte),
        .rx_last    (rx_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .start      (start),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Record every memory write seen on the falling edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " rx_ready"},   32'(rx_ready),  32'd0);
        check({tag, " imem_we"},    32'(imem_we),   32'd0);
        check({tag, " imem_addr"},  imem_addr,      32'd0);
        check({tag, " imem_wdata"}, imem_wdata,     32'd0);
        check({tag, " start"},      32'(start),     32'd0);
        check({tag, " load_done"},  32'(load_done), 32'd0);
        check({tag, " err"},        32'(err),       32'd0);
    endtask

    // Called on a falling edge; waits a bounded number of cycles for rx_ready.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (rx_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, " rx_ready after reset"}, 32'(rx_ready), 32'd1);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_byte  = 8'h00;
        rst_n    = 1'b0;
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Back-to-back bytes from the table; write port checked the cycle after each.
    task automatic run_vecs(input int first, input int n, input string tag);
        for (int i = first; i < first + n; i++) begin
            rx_valid = 1'b1;
            rx_byte  = vecs[i].b;
            rx_last  = vecs[i].last;
            check($sformatf("%s ready byte %0d", tag, i - first), 32'(rx_ready), 32'd1);
            @(negedge clk);
            check($sformatf("%s we byte %0d", tag, i - first), 32'(imem_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("%s addr byte %0d", tag, i - first), imem_addr, vecs[i].addr);
                check($sformatf("%s data byte %0d", tag, i - first), imem_wdata, vecs[i].data);
            end
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    // From the falling edge after the final write: load_done next, start 4 later.
    task automatic check_tail(input string tag);
        check({tag, " ready low in flush"}, 32'(rx_ready), 32'd0);
        @(negedge clk);
        check({tag, " load_done"}, 32'(load_done), 32'd1);
        check({tag, " we after final"}, 32'(imem_we), 32'd0);
        check({tag, " start early"}, 32'(start), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("%s start hold %0d", tag, k), 32'(start), 32'd0);
        end
        @(negedge clk);
        check({tag, " start"}, 32'(start), 32'd1);
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int          sent;
        int          cyc;
        logic        v;
        logic [31:0] w;

        // Eight-byte image, then a five-byte image with a padded last word.
        vecs[0]  = '{8'h13, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{8'h00, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[2]  = '{8'h00, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[3]  = '{8'h00, 1'b0, 1'b1, 32'h0, 32'h00000013};
        vecs[4]  = '{8'h93, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[6]  = '{8'h10, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[7]  = '{8'h00, 1'b1, 1'b1, 32'h4, 32'h00100093};
        vecs[8]  = '{8'hAA, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[9]  = '{8'hBB, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[10] = '{8'hCC, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{8'hDD, 1'b0, 1'b1, 32'h0, 32'hDDCCBBAA};
        vecs[12] = '{8'hEE, 1'b1, 1'b1, 32'h4, 32'h000000EE};

        // Reset state.
        #1;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("s1");

        // Scenario 1: eight-byte image.
        run_vecs(0, 8, "s1");
        check_tail("s1");
        check("s1 write count", 32'(wr_data_q.size()), 32'd2);

        // Scenario 2: partial final word.
        do_reset();
        wait_ready("s2");
        run_vecs(8, 5, "s2");
        check_tail("s2");

        // Scenario 3: random gaps on rx_valid.
        do_reset();
        wait_ready("s3");
        sent = 0;
        cyc  = 0;
        while (sent < 8 && cyc < 200) begin
            v        = 1'($urandom_range(0, 1));
            rx_valid = v;
            rx_byte  = vecs[sent].b;
            rx_last  = vecs[sent].last;
            if (rx_ready !== 1'b1)
                check($sformatf("s3 ready during load byte %0d", sent), 32'(rx_ready), 32'd1);
            @(negedge clk);
            if (v) sent++;
            cyc++;
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        check("s3 bytes sent", 32'(sent), 32'd8);
        check("s3 ready low after last", 32'(rx_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("s3 write count", 32'(wr_data_q.size()), 32'd2);
        if (wr_data_q.size() == 2) begin
            check("s3 addr 0", wr_addr_q[0], 32'h0);
            check("s3 data 0", wr_data_q[0], 32'h00000013);
            check("s3 addr 1", wr_addr_q[1], 32'h4);
            check("s3 data 1", wr_data_q[1], 32'h00100093);
        end
        check("s3 load_done", 32'(load_done), 32'd1);

        // Scenario 4: overflow with IMEM_WORDS=4; rx_last on the 17th byte.
        do_reset();
        wait_ready("s4");
        for (int i = 0; i < 17; i++) begin
            rx_valid = 1'b1;
            rx_byte  = 8'h10 + 8'(i);
            rx_last  = (i == 16);
            check($sformatf("s4 ready byte %0d", i), 32'(rx_ready), 32'd1);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        check("s4 err", 32'(err), 32'd1);
        check("s4 ready after overflow", 32'(rx_ready), 32'd0);
        check("s4 no write for 17th", 32'(imem_we), 32'd0);
        repeat (10) @(negedge clk);
        check("s4 err sticky", 32'(err), 32'd1);
        check("s4 start", 32'(start), 32'd0);
        check("s4 load_done", 32'(load_done), 32'd0);
        check("s4 write count", 32'(wr_data_q.size()), 32'd4);
        if (wr_data_q.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < 4; k++)
                    w[8*k +: 8] = 8'h10 + 8'(4*j + k);
                check($sformatf("s4 addr %0d", j), wr_addr_q[j], 32'(4*j));
                check($sformatf("s4 data %0d", j), wr_data_q[j], w);
            end
        end

        // Scenario 5: reset after six bytes, then a clean reload.
        do_reset();
        wait_ready("s5");
        run_vecs(0, 6, "s5a");
        rx_valid = 1'b1;
        rx_byte  = 8'h10;
        rst_n    = 1'b0;
        #1;
        check_reset_values("s5 mid-load reset");
        @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (5) @(negedge clk);
        check("s5 no write after reset", 32'(wr_data_q.size()), 32'd1);
        check("s5 load_done idle", 32'(load_done), 32'd0);
        check("s5 ready idle", 32'(rx_ready), 32'd1);
        run_vecs(0, 8, "s5b");
        check_tail("s5b");
        check("s5 write count", 32'(wr_data_q.size()), 32'd3);

        // Scenario 6: bytes offered after start are ignored.
        rx_valid = 1'b1;
        rx_byte  = 8'h55;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check($sformatf("s6 ready %0d", i), 32'(rx_ready), 32'd0);
            check($sformatf("s6 we %0d", i), 32'(imem_we), 32'd0);
            check($sformatf("s6 start %0d", i), 32'(start), 32'd1);
        end
        rx_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
